// File: rtl/qdr_mbist_pkg.sv
// Shared types and the write/compare pattern generator for the QDR SRAM MBIST engine.
package qdr_mbist_pkg;

  localparam int unsigned ADDR_BITS_DEF = 18;
  localparam int unsigned DATA_BITS_DEF = 8 * ADDR_BITS_DEF;
  localparam int unsigned PAT_ADDR_MAX  = 32;
  localparam int unsigned PAT_DATA_MAX  = 8 * PAT_ADDR_MAX;
  localparam int unsigned ERR_BITS      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } mbist_state_t;

  // {8{addr ^ seed}}, inverted on pass 1; packs eight addr_bits-wide copies from bit 0 up.
  function automatic logic [PAT_DATA_MAX-1:0] pattern(
    input logic [PAT_ADDR_MAX-1:0] addr,
    input logic [PAT_ADDR_MAX-1:0] seed,
    input logic                    pass,
    input int unsigned             addr_bits
  );
    logic [PAT_ADDR_MAX-1:0] word;
    logic [PAT_DATA_MAX-1:0] pat;
    word = (addr ^ seed) ^ {PAT_ADDR_MAX{pass}};
    pat  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned b = 0; b < PAT_ADDR_MAX; b++) begin
        if (b < addr_bits) pat[8'(i * addr_bits + b)] = word[5'(b)];
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/qdr_mbist_checker.sv
// Read-return checker: tracks the expected address, compares data, counts errors and
// captures the address of the first error since start.
module qdr_mbist_checker
  import qdr_mbist_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk_ram_ctl,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 pass_clr,
  input  logic                 en,
  input  logic                 pass,
  input  logic [ADDR_BITS-1:0] seed,
  input  logic                 ram_rd_data_valid,
  input  logic [DATA_BITS-1:0] ram_rd_data,
  input  logic                 outst_zero,
  output logic                 err_c,
  output logic [ERR_BITS-1:0]  err_count,
  output logic [ADDR_BITS-1:0] fail_addr
);

  logic [ADDR_BITS-1:0] check_addr_q;
  logic                 first_seen_q;
  logic [DATA_BITS-1:0] exp_c;

  assign exp_c = DATA_BITS'(pattern(PAT_ADDR_MAX'(check_addr_q), PAT_ADDR_MAX'(seed),
                                    pass, ADDR_BITS));

  // A return with nothing outstanding is an error regardless of its data.
  assign err_c = en && ram_rd_data_valid && (outst_zero || (ram_rd_data != exp_c));

  always_ff @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) begin
      check_addr_q <= '0;
      first_seen_q <= 1'b0;
      err_count    <= '0;
      fail_addr    <= '0;
    end else if (clear) begin
      check_addr_q <= '0;
      first_seen_q <= 1'b0;
      err_count    <= '0;
      fail_addr    <= '0;
    end else begin
      if (pass_clr) check_addr_q <= '0;
      else if (en && ram_rd_data_valid) check_addr_q <= check_addr_q + ADDR_BITS'(1);

      if (err_c) begin
        if (err_count != '1) err_count <= err_count + ERR_BITS'(1);
        if (!first_seen_q) begin
          fail_addr    <= check_addr_q;
          first_seen_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qdr_mbist_engine.sv
// Two-pass march-style MBIST for a QDR SRAM controller: write pattern, read back,
// drain returns, repeat with inverted pattern; reports errors and read-return timeout.
module qdr_mbist_engine
  import qdr_mbist_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk_ram_ctl,
  input  logic                 rst,
  input  logic                 mbist_start,
  input  logic [ADDR_BITS-1:0] mbist_seed,
  input  logic [ADDR_BITS-1:0] mbist_end_addr,
  output logic                 ram_wr_en_bist,
  output logic [ADDR_BITS-1:0] ram_wr_addr_bist,
  output logic [DATA_BITS-1:0] ram_wr_data_bist,
  output logic                 ram_rd_en_bist,
  output logic [ADDR_BITS-1:0] ram_rd_addr_bist,
  input  logic                 ram_rd_data_valid,
  input  logic [DATA_BITS-1:0] ram_rd_data,
  output logic                 mbist_busy,
  output logic                 mbist_done,
  output logic                 mbist_fail,
  output logic                 mbist_timeout,
  output logic [ERR_BITS-1:0]  mbist_err_count,
  output logic [ADDR_BITS-1:0] mbist_fail_addr
);

  localparam int unsigned OUT_BITS = ADDR_BITS + 1;
  localparam int unsigned TMO_BITS = $clog2(TIMEOUT + 1);

  mbist_state_t         state_q, state_nxt;
  logic [ADDR_BITS-1:0] addr_q, addr_nxt;
  logic [ADDR_BITS-1:0] seed_q, end_q;
  logic                 pass_q, pass_nxt;
  logic                 start_acc_c, pass_clr_c, wr_c, rd_c;
  logic [OUT_BITS-1:0]  outst_q;
  logic                 outst_zero_c, dec_c;
  logic [TMO_BITS-1:0]  tmo_cnt_q;
  logic                 tmo_window_c, tmo_hit_c;
  logic                 chk_en_c, chk_err_c;
  logic [DATA_BITS-1:0] wr_pat_c;

  assign outst_zero_c = (outst_q == '0);
  assign dec_c        = ram_rd_data_valid && !outst_zero_c;
  assign chk_en_c     = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign tmo_window_c = ((state_q == ST_READ) || (state_q == ST_DRAIN)) && !outst_zero_c &&
                        !ram_rd_data_valid;
  assign tmo_hit_c    = tmo_window_c && (tmo_cnt_q == TMO_BITS'(TIMEOUT - 1));
  assign wr_pat_c     = DATA_BITS'(pattern(PAT_ADDR_MAX'(addr_q), PAT_ADDR_MAX'(seed_q),
                                           pass_q, ADDR_BITS));

  // Next-state and command issue
  always_comb begin
    state_nxt   = state_q;
    addr_nxt    = addr_q;
    pass_nxt    = pass_q;
    start_acc_c = 1'b0;
    pass_clr_c  = 1'b0;
    wr_c        = 1'b0;
    rd_c        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mbist_start) begin
          start_acc_c = 1'b1;
          addr_nxt    = '0;
          pass_nxt    = 1'b0;
          state_nxt   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_c = 1'b1;
        if (addr_q == end_q) begin
          addr_nxt  = '0;
          state_nxt = ST_READ;
        end else begin
          addr_nxt = addr_q + ADDR_BITS'(1);
        end
      end
      ST_READ: begin
        if (tmo_hit_c) begin
          state_nxt = ST_DONE;
        end else begin
          rd_c = 1'b1;
          if (addr_q == end_q) begin
            addr_nxt  = '0;
            state_nxt = ST_DRAIN;
          end else begin
            addr_nxt = addr_q + ADDR_BITS'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The last read is still on the command register in the first DRAIN cycle.
        if (tmo_hit_c) begin
          state_nxt = ST_DONE;
        end else if (outst_zero_c && !ram_rd_en_bist) begin
          if (!pass_q) begin
            pass_nxt   = 1'b1;
            addr_nxt   = '0;
            pass_clr_c = 1'b1;
            state_nxt  = ST_WRITE;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latched configuration, command and status registers
  always_ff @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      pass_q           <= 1'b0;
      seed_q           <= '0;
      end_q            <= '0;
      ram_wr_en_bist   <= 1'b0;
      ram_wr_addr_bist <= '0;
      ram_wr_data_bist <= '0;
      ram_rd_en_bist   <= 1'b0;
      ram_rd_addr_bist <= '0;
      mbist_busy       <= 1'b0;
      mbist_done       <= 1'b0;
      mbist_fail       <= 1'b0;
      mbist_timeout    <= 1'b0;
    end else begin
      state_q          <= state_nxt;
      addr_q           <= addr_nxt;
      pass_q           <= pass_nxt;
      if (start_acc_c) begin
        seed_q <= mbist_seed;
        end_q  <= mbist_end_addr;
      end
      ram_wr_en_bist   <= wr_c;
      ram_wr_addr_bist <= wr_c ? addr_q : '0;
      ram_wr_data_bist <= wr_c ? wr_pat_c : '0;
      ram_rd_en_bist   <= rd_c;
      ram_rd_addr_bist <= rd_c ? addr_q : '0;
      mbist_busy       <= (state_nxt == ST_WRITE) || (state_nxt == ST_READ) ||
                          (state_nxt == ST_DRAIN);
      mbist_done       <= (state_nxt == ST_DONE);
      if (start_acc_c) mbist_timeout <= 1'b0;
      else if (tmo_hit_c) mbist_timeout <= 1'b1;
      if (start_acc_c) mbist_fail <= 1'b0;
      else if (tmo_hit_c || chk_err_c) mbist_fail <= 1'b1;
    end
  end

  // Reads in flight between command register and return port
  always_ff @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
    end else if (start_acc_c) begin
      outst_q <= '0;
    end else begin
      case ({ram_rd_en_bist, dec_c})
        2'b10:   outst_q <= outst_q + OUT_BITS'(1);
        2'b01:   outst_q <= outst_q - OUT_BITS'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Consecutive cycles waiting on a return with reads outstanding
  always_ff @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else if (tmo_window_c && !tmo_hit_c) tmo_cnt_q <= tmo_cnt_q + TMO_BITS'(1);
    else tmo_cnt_q <= '0;
  end

  qdr_mbist_checker #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_checker (
    .clk_ram_ctl       (clk_ram_ctl),
    .rst               (rst),
    .clear             (start_acc_c),
    .pass_clr          (pass_clr_c),
    .en                (chk_en_c),
    .pass              (pass_q),
    .seed              (seed_q),
    .ram_rd_data_valid (ram_rd_data_valid),
    .ram_rd_data       (ram_rd_data),
    .outst_zero        (outst_zero_c),
    .err_c             (chk_err_c),
    .err_count         (mbist_err_count),
    .fail_addr         (mbist_fail_addr)
  );

endmodule

// File: tb/tb_qdr_mbist_engine.sv
// Bench for qdr_mbist_engine: latency-5 SRAM model with fault hooks, queue scoreboard
// fed by the stimulus and drained by a negedge monitor.
module tb_qdr_mbist_engine;

  localparam int unsigned AB = 18;
  localparam int unsigned DB = 144;

  logic          clk_ram_ctl = 1'b0;
  logic          rst = 1'b1;
  logic          mbist_start = 1'b0;
  logic [AB-1:0] mbist_seed = '0;
  logic [AB-1:0] mbist_end_addr = '0;
  logic          ram_wr_en_bist, ram_rd_en_bist;
  logic [AB-1:0] ram_wr_addr_bist, ram_rd_addr_bist;
  logic [DB-1:0] ram_wr_data_bist;
  logic          ram_rd_data_valid;
  logic [DB-1:0] ram_rd_data;
  logic          mbist_busy, mbist_done, mbist_fail, mbist_timeout;
  logic [31:0]   mbist_err_count;
  logic [AB-1:0] mbist_fail_addr;

  always #5 clk_ram_ctl = ~clk_ram_ctl;

  qdr_mbist_engine #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(1024)) dut (
    .clk_ram_ctl       (clk_ram_ctl),
    .rst               (rst),
    .mbist_start       (mbist_start),
    .mbist_seed        (mbist_seed),
    .mbist_end_addr    (mbist_end_addr),
    .ram_wr_en_bist    (ram_wr_en_bist),
    .ram_wr_addr_bist  (ram_wr_addr_bist),
    .ram_wr_data_bist  (ram_wr_data_bist),
    .ram_rd_en_bist    (ram_rd_en_bist),
    .ram_rd_addr_bist  (ram_rd_addr_bist),
    .ram_rd_data_valid (ram_rd_data_valid),
    .ram_rd_data       (ram_rd_data),
    .mbist_busy        (mbist_busy),
    .mbist_done        (mbist_done),
    .mbist_fail        (mbist_fail),
    .mbist_timeout     (mbist_timeout),
    .mbist_err_count   (mbist_err_count),
    .mbist_fail_addr   (mbist_fail_addr)
  );

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic        fail;
    logic        tmo;
    logic [31:0] err;
    logic [AB-1:0] faddr;
  } res_t;

  wr_exp_t       wr_q[$];
  logic [AB-1:0] rd_q[$];
  res_t          res_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_valid_edge = 0;
  int   done_edge = 0;
  logic done_prev = 1'b0;
  logic stuck_en = 1'b0;
  logic drop_en = 1'b0;

  function automatic logic [DB-1:0] pat(input logic [AB-1:0] a, input logic [AB-1:0] seed,
                                        input logic p);
    logic [AB-1:0] w;
    w = a ^ seed;
    if (p) w = ~w;
    return {8{w}};
  endfunction

  function automatic res_t mk_res(input logic fail, input logic tmo, input logic [31:0] err,
                                  input logic [AB-1:0] faddr);
    res_t r;
    r.fail  = fail;
    r.tmo   = tmo;
    r.err   = err;
    r.faddr = faddr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: 5-cycle read latency, optional bit-3 stuck-at-1 at addr 5, optional drop of addr 7
  logic [DB-1:0] mem [0:255];
  logic [4:0]    pv;
  logic [DB-1:0] pd [0:4];

  always @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      if (ram_wr_en_bist) mem[ram_wr_addr_bist[7:0]] <= ram_wr_data_bist;
      pv    <= {pv[3:0], ram_rd_en_bist && !(drop_en && ram_rd_addr_bist == AB'(7))};
      pd[0] <= mem[ram_rd_addr_bist[7:0]] |
               ((stuck_en && ram_rd_addr_bist == AB'(5)) ? DB'(8) : DB'(0));
      for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
    end
  end

  assign ram_rd_data_valid = pv[4];
  assign ram_rd_data       = pd[4];

  always @(posedge clk_ram_ctl) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a command or completes
  always @(negedge clk_ram_ctl) begin
    wr_exp_t e;
    logic [AB-1:0] ra;
    res_t r;
    if (!rst) begin
      chk("wr_rd_exclusive", 256'(ram_wr_en_bist & ram_rd_en_bist), 256'(0));
      if (ram_wr_en_bist) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 256'(1), 256'(0));
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", 256'(ram_wr_addr_bist), 256'(e.addr));
          chk("wr_data", 256'(ram_wr_data_bist), 256'(e.data));
        end
      end else begin
        chk("wr_idle_zero", 256'({ram_wr_addr_bist, ram_wr_data_bist}), 256'(0));
      end
      if (ram_rd_en_bist) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 256'(1), 256'(0));
        else begin
          ra = rd_q.pop_front();
          chk("rd_addr", 256'(ram_rd_addr_bist), 256'(ra));
        end
      end else begin
        chk("rd_idle_zero", 256'(ram_rd_addr_bist), 256'(0));
      end
      // The DUT samples this return on the next rising edge
      if (ram_rd_data_valid) last_valid_edge = cyc + 1;
      if (mbist_done && !done_prev) begin
        done_edge = cyc;
        if (res_q.size() == 0) chk("done_unexpected", 256'(1), 256'(0));
        else begin
          r = res_q.pop_front();
          chk("result", 256'({mbist_fail, mbist_timeout, mbist_err_count, mbist_fail_addr}),
              256'(r));
          chk("busy_at_done", 256'(mbist_busy), 256'(0));
        end
      end
    end
    done_prev = mbist_done;
  end

  task automatic push_passes(input logic [AB-1:0] seed, input logic [AB-1:0] end_a,
                             input int passes);
    wr_exp_t e;
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a <= int'(end_a); a++) begin
        e.addr = AB'(a);
        e.data = pat(AB'(a), seed, p[0]);
        wr_q.push_back(e);
        rd_q.push_back(AB'(a));
      end
    end
  endtask

  task automatic run_test(input logic [AB-1:0] seed, input logic [AB-1:0] end_a,
                          input int passes, input logic auto_push, input logic poke,
                          input res_t exp);
    logic got, poked;
    if (auto_push) push_passes(seed, end_a, passes);
    res_q.push_back(exp);
    @(negedge clk_ram_ctl);
    mbist_seed     = seed;
    mbist_end_addr = end_a;
    mbist_start    = 1'b1;
    @(negedge clk_ram_ctl);
    mbist_start = 1'b0;
    chk("start_busy", 256'(mbist_busy), 256'(1));
    chk("start_cleared", 256'({mbist_done, mbist_fail, mbist_timeout, mbist_err_count,
                               mbist_fail_addr}), 256'(0));
    got   = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk_ram_ctl);
      if (mbist_done) got = 1'b1;
      else if (poke && ram_rd_en_bist && !poked) begin
        mbist_start = 1'b1;
        poked       = 1'b1;
      end else mbist_start = 1'b0;
    end
    mbist_start = 1'b0;
    if (!got) chk("done_wait_expired", 256'(0), 256'(1));
    if (poke) chk("start_poked_in_read", 256'(poked), 256'(1));
    @(negedge clk_ram_ctl);
    chk("done_held", 256'(mbist_done), 256'(1));
    chk("wr_q_drained", 256'(wr_q.size()), 256'(0));
    chk("rd_q_drained", 256'(rd_q.size()), 256'(0));
    chk("res_q_drained", 256'(res_q.size()), 256'(0));
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({ram_wr_en_bist, ram_wr_addr_bist, ram_wr_data_bist, ram_rd_en_bist,
                 ram_rd_addr_bist, mbist_busy, mbist_done, mbist_fail, mbist_timeout,
                 mbist_err_count, mbist_fail_addr});
  endfunction

  initial begin
    wr_exp_t e;
    logic    hit;
    repeat (3) @(negedge clk_ram_ctl);
    chk("reset_outputs", all_outs(), 256'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk_ram_ctl);
    chk("idle_after_reset", 256'({mbist_busy, mbist_done, ram_wr_en_bist, ram_rd_en_bist}),
        256'(0));

    // Clean two-pass run, 16 addresses
    run_test(AB'(18'h00ABC), AB'(15), 2, 1'b1, 1'b0, mk_res(1'b0, 1'b0, 32'd0, AB'(0)));

    // Start pulsed while reading must not disturb the run
    run_test(AB'(18'h12345), AB'(15), 2, 1'b1, 1'b1, mk_res(1'b0, 1'b0, 32'd0, AB'(0)));

    // Bit 3 stuck-at-1 at addr 5, seed 0: pass 0 expects bit 3 = 0 (error), pass 1 expects 1
    stuck_en = 1'b1;
    run_test(AB'(18'h00000), AB'(15), 2, 1'b1, 1'b0, mk_res(1'b1, 1'b0, 32'd1, AB'(5)));
    stuck_en = 1'b0;

    // Start from DONE after a failing run clears results
    run_test(AB'(18'h2A5A5), AB'(5), 2, 1'b1, 1'b0, mk_res(1'b0, 1'b0, 32'd0, AB'(0)));

    // Lost return for addr 7: run ends in pass 0 on timeout
    drop_en = 1'b1;
    run_test(AB'(18'h00ABC), AB'(7), 1, 1'b1, 1'b0, mk_res(1'b1, 1'b1, 32'd0, AB'(0)));
    drop_en = 1'b0;
    chk("timeout_latency", 256'(done_edge - last_valid_edge), 256'(1024));

    // Reset asserted during the 10th write of pass 0
    push_passes(AB'(18'h01234), AB'(15), 1);
    @(negedge clk_ram_ctl);
    mbist_seed     = AB'(18'h01234);
    mbist_end_addr = AB'(15);
    mbist_start    = 1'b1;
    @(negedge clk_ram_ctl);
    mbist_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_ram_ctl);
      if (ram_wr_en_bist && ram_wr_addr_bist == AB'(9)) hit = 1'b1;
    end
    chk("tenth_write_seen", 256'(hit), 256'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 256'(0));
    @(posedge clk_ram_ctl);
    #1;
    chk("rst_edge_outputs", all_outs(), 256'(0));
    wr_q.delete();
    rd_q.delete();
    res_q.delete();
    @(negedge clk_ram_ctl);
    rst = 1'b0;
    repeat (4) @(negedge clk_ram_ctl);
    chk("idle_after_midrun_reset",
        256'({mbist_busy, mbist_done, ram_wr_en_bist, ram_rd_en_bist}), 256'(0));
    run_test(AB'(18'h0F0F0), AB'(3), 2, 1'b1, 1'b0, mk_res(1'b0, 1'b0, 32'd0, AB'(0)));

    // Single-address run with all-ones seed: pass 0 writes all ones, pass 1 all zeros
    e.addr = AB'(0);
    e.data = {8{18'h3FFFF}};
    wr_q.push_back(e);
    e.data = 144'h0;
    wr_q.push_back(e);
    rd_q.push_back(AB'(0));
    rd_q.push_back(AB'(0));
    run_test(AB'(18'h3FFFF), AB'(0), 2, 1'b0, 1'b0, mk_res(1'b0, 1'b0, 32'd0, AB'(0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
